fetch_queue: RTL and testbench

Instruction fetch front end for the core pipeline. Generates sequential fetch addresses, issues one-at-a-time requests to the L1 instruction cache, and buffers returned words with their PCs in a small FIFO. The FIFO feeds the decode stage. A branch or jump redirect from decode/execute flushes the buffer and restarts fetch at a new PC, and any in-flight cache response is discarded.

---
 rtl/fetch_queue.sv | 129 ++++++++++++
 tb/tb_fetch_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end. It issues one outstanding icache request at a time and
// buffers the returned words, with their PCs, in a small FIFO that feeds decode.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PC_W     = 16,
  parameter int unsigned RESET_PC = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  input  logic            imem_ready,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [31:0]     inst_data,
  output logic [PC_W-1:0] inst_pc,
  input  logic            inst_accept
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            imem_req_q, imem_req_d;
  logic [PC_W-1:0] imem_addr_q, imem_addr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     mem_data_q [DEPTH];
  logic [31:0]     mem_data_d [DEPTH];
  logic [PC_W-1:0] mem_pc_q   [DEPTH];
  logic [PC_W-1:0] mem_pc_d   [DEPTH];
  logic            push;
  logic            pop;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    imem_req_d  = 1'b0;
    imem_addr_d = imem_addr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    mem_data_d  = mem_data_q;
    mem_pc_d    = mem_pc_q;
    push        = 1'b0;
    pop         = (count_q != '0) && inst_accept;

    if (redirect) begin
      // A response landing with the redirect closes the outstanding request; otherwise it must be dropped later.
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      state_d    = ((state_q != IDLE) && !imem_ready) ? DROP : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if ((count_q - CW'(pop)) < CW'(DEPTH)) begin
            imem_req_d  = 1'b1;
            imem_addr_d = fetch_pc_q;
            state_d     = WAIT;
          end
        end
        WAIT: begin
          if (imem_ready) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 1'b1;
            state_d    = IDLE;
          end
        end
        DROP: begin
          if (imem_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (push) begin
        mem_data_d[wr_ptr_q] = imem_data;
        mem_pc_d[wr_ptr_q]   = fetch_pc_q;
        wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= PC_W'(RESET_PC);
      imem_req_q  <= 1'b0;
      imem_addr_q <= PC_W'(RESET_PC);
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      mem_data_q  <= '{default: '0};
      mem_pc_q    <= '{default: '0};
    end else if (clk_en) begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      mem_data_q  <= mem_data_d;
      mem_pc_q    <= mem_pc_d;
    end
  end

  // The strobe is masked while stalled and shows up in exactly one enabled cycle.
  assign imem_req   = imem_req_q & clk_en;
  assign imem_addr  = imem_addr_q;
  assign inst_valid = (count_q != '0);
  assign inst_data  = mem_data_q[rd_ptr_q];
  assign inst_pc    = mem_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a simple latency-programmable icache model
// and per-scenario tasks that check against hand-computed values.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_en = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic        imem_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [15:0] inst_pc;
  logic        inst_accept = 1'b0;

  int passed = 0;
  int total  = 0;

  bit          cache_on = 1'b1;
  bit          cache_const = 1'b1;
  int          lat = 2;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [15:0] paddr = '0;

  logic [15:0] req_log[$];
  logic [15:0] pop_pc[$];
  logic [31:0] pop_data[$];

  fetch_queue #(.DEPTH(4), .PC_W(16), .RESET_PC(10)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_ready(imem_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_accept(inst_accept)
  );

  initial forever #5 clk = ~clk;

  // Logs what the coming edge will see, advances one cycle, then updates the cache model at the negedge.
  task automatic tick();
    if (rst && clk_en && imem_req) req_log.push_back(imem_addr);
    if (rst && clk_en && inst_valid && inst_accept) begin
      pop_pc.push_back(inst_pc);
      pop_data.push_back(inst_data);
    end
    @(posedge clk);
    @(negedge clk);
    imem_ready = 1'b0;
    if (!rst || !cache_on) pend = 1'b0;
    else if (clk_en) begin
      if (pend) begin
        if (cnt <= 1) begin
          imem_ready = 1'b1;
          imem_data  = cache_const ? 32'h1111_1111 : {16'hC0DE, paddr};
          pend       = 1'b0;
        end else cnt--;
      end
      if (imem_req) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = imem_addr;
      end
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_pc.delete();
    pop_data.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0; clk_en = 1'b1; redirect = 1'b0; inst_accept = 1'b0;
    imem_ready = 1'b0; pend = 1'b0; cache_on = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    cache_const = 1'b1; lat = 2;
    do_reset();
    total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else passed++;
    total++; if (imem_addr !== 16'd10) $display("FAIL rst_addr: got %h want 000a", imem_addr); else passed++;
    total++; if (inst_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", inst_valid); else passed++;
    total++; if (inst_data !== 32'h0) $display("FAIL rst_data: got %h want 0", inst_data); else passed++;
    total++; if (inst_pc !== 16'h0) $display("FAIL rst_pc: got %h want 0", inst_pc); else passed++;
    rst = 1'b1;
    clear_logs();
    tick();
    total++; if (imem_req !== 1'b1) $display("FAIL first_req: got %b want 1", imem_req); else passed++;
    total++; if (imem_addr !== 16'd10) $display("FAIL first_addr: got %h want 000a", imem_addr); else passed++;
  endtask

  task automatic test_startup();
    int n;
    inst_accept = 1'b1;
    n = 0;
    while ((req_log.size() < 3 || pop_pc.size() < 1) && n < 60) begin tick(); n++; end
    total++; if (req_log.size() < 3 || req_log[0] !== 16'd10) $display("FAIL start_addr0: got %p want 000a", req_log); else passed++;
    total++; if (req_log.size() < 3 || req_log[1] !== 16'd11) $display("FAIL start_addr1: got %p want 000b", req_log); else passed++;
    total++; if (req_log.size() < 3 || req_log[2] !== 16'd12) $display("FAIL start_addr2: got %p want 000c", req_log); else passed++;
    total++; if (pop_pc.size() < 1 || pop_pc[0] !== 16'd10) $display("FAIL start_pc: got %p want 000a", pop_pc); else passed++;
    total++; if (pop_data.size() < 1 || pop_data[0] !== 32'h1111_1111) $display("FAIL start_data: got %p want 11111111", pop_data); else passed++;
  endtask

  task automatic test_back_pressure();
    cache_const = 1'b0; lat = 1;
    do_reset();
    rst = 1'b1;
    clear_logs();
    repeat (40) tick();
    total++; if (req_log.size() != 4) $display("FAIL bp_nreq: got %0d want 4", req_log.size()); else passed++;
    total++; if (req_log.size() < 4 || req_log[3] !== 16'd13) $display("FAIL bp_last: got %p want 000d last", req_log); else passed++;
    total++; if (inst_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", inst_valid); else passed++;
    total++; if (inst_pc !== 16'd10) $display("FAIL bp_pc: got %h want 000a", inst_pc); else passed++;
    total++; if (inst_data !== 32'hC0DE_000A) $display("FAIL bp_data: got %h want c0de000a", inst_data); else passed++;
    clear_logs();
    inst_accept = 1'b1;
    tick();
    inst_accept = 1'b0;
    repeat (20) tick();
    total++; if (pop_pc.size() != 1 || pop_pc[0] !== 16'd10) $display("FAIL bp_pop: got %p want {000a}", pop_pc); else passed++;
    total++; if (req_log.size() != 1 || req_log[0] !== 16'd14) $display("FAIL bp_newreq: got %p want {000e}", req_log); else passed++;
    total++; if (inst_pc !== 16'd11) $display("FAIL bp_head: got %h want 000b", inst_pc); else passed++;
  endtask

  task automatic test_redirect_wait();
    int n;
    cache_const = 1'b0; lat = 3;
    do_reset();
    rst = 1'b1;
    tick();
    total++; if (imem_req !== 1'b1) $display("FAIL rw_req: got %b want 1", imem_req); else passed++;
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    clear_logs();
    total++; if (inst_valid !== 1'b0) $display("FAIL rw_flush: got %b want 0", inst_valid); else passed++;
    n = 0;
    while (!inst_valid && n < 60) begin tick(); n++; end
    total++; if (inst_valid !== 1'b1) $display("FAIL rw_timeout: got %b want 1", inst_valid); else passed++;
    total++; if (inst_pc !== 16'h0040) $display("FAIL rw_pc: got %h want 0040", inst_pc); else passed++;
    total++; if (inst_data !== 32'hC0DE_0040) $display("FAIL rw_data: got %h want c0de0040", inst_data); else passed++;
    total++; if (req_log.size() != 1 || req_log[0] !== 16'h0040) $display("FAIL rw_addr: got %p want {0040}", req_log); else passed++;
  endtask

  task automatic test_redirect_ready_pop();
    int n;
    cache_const = 1'b0; lat = 2;
    do_reset();
    rst = 1'b1;
    n = 0;
    while (!(imem_req && imem_addr == 16'd13) && n < 60) begin tick(); n++; end
    total++; if (!(imem_req === 1'b1 && imem_addr === 16'd13)) $display("FAIL rrp_req13: got %b/%h want 1/000d", imem_req, imem_addr); else passed++;
    cache_on = 1'b0;
    tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 16'd10) $display("FAIL rrp_head: got %b/%h want 1/000a", inst_valid, inst_pc); else passed++;
    imem_ready = 1'b1; imem_data = 32'hDEAD_BEEF;
    redirect = 1'b1; redirect_pc = 16'h0200; inst_accept = 1'b1;
    tick();
    redirect = 1'b0; inst_accept = 1'b0;
    total++; if (inst_valid !== 1'b0) $display("FAIL rrp_flush: got %b want 0", inst_valid); else passed++;
    tick();
    total++; if (imem_req !== 1'b1) $display("FAIL rrp_req: got %b want 1", imem_req); else passed++;
    total++; if (imem_addr !== 16'h0200) $display("FAIL rrp_addr: got %h want 0200", imem_addr); else passed++;
    tick();
    total++; if (inst_valid !== 1'b0) $display("FAIL rrp_nopush: got %b want 0", inst_valid); else passed++;
  endtask

  task automatic test_wrap();
    cache_const = 1'b0; lat = 1;
    do_reset();
    inst_accept = 1'b1;
    rst = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    clear_logs();
    total++; if (imem_req !== 1'b0) $display("FAIL wrap_noreq: got %b want 0", imem_req); else passed++;
    repeat (20) tick();
    total++; if (req_log.size() < 2 || req_log[0] !== 16'hFFFF) $display("FAIL wrap_addr0: got %p want ffff", req_log); else passed++;
    total++; if (req_log.size() < 2 || req_log[1] !== 16'h0000) $display("FAIL wrap_addr1: got %p want 0000", req_log); else passed++;
    total++; if (pop_pc.size() < 2 || pop_pc[0] !== 16'hFFFF) $display("FAIL wrap_pc0: got %p want ffff", pop_pc); else passed++;
    total++; if (pop_data.size() < 2 || pop_data[0] !== 32'hC0DE_FFFF) $display("FAIL wrap_data0: got %p want c0deffff", pop_data); else passed++;
    total++; if (pop_pc.size() < 2 || pop_pc[1] !== 16'h0000) $display("FAIL wrap_pc1: got %p want 0000", pop_pc); else passed++;
    total++; if (pop_data.size() < 2 || pop_data[1] !== 32'hC0DE_0000) $display("FAIL wrap_data1: got %p want c0de0000", pop_data); else passed++;
  endtask

  task automatic test_stall();
    int n;
    cache_const = 1'b0; lat = 2;
    do_reset();
    rst = 1'b1;
    n = 0;
    while (!inst_valid && n < 40) begin tick(); n++; end
    total++; if (inst_valid !== 1'b1) $display("FAIL stall_timeout: got %b want 1", inst_valid); else passed++;
    clk_en = 1'b0;
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (imem_req !== 1'b0) $display("FAIL stall_req%0d: got %b want 0", i, imem_req); else passed++;
      total++; if (inst_valid !== 1'b1) $display("FAIL stall_valid%0d: got %b want 1", i, inst_valid); else passed++;
      total++; if (inst_pc !== 16'd10) $display("FAIL stall_pc%0d: got %h want 000a", i, inst_pc); else passed++;
      total++; if (inst_data !== 32'hC0DE_000A) $display("FAIL stall_data%0d: got %h want c0de000a", i, inst_data); else passed++;
    end
    clk_en = 1'b1;
    inst_accept = 1'b1;
    repeat (30) tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (req_log.size() < 4 || req_log[i] !== 16'(11 + i)) $display("FAIL resume_addr%0d: got %p want %h", i, req_log, 16'(11 + i));
      else passed++;
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (pop_pc.size() < 5 || pop_pc[i] !== 16'(10 + i) || pop_data[i] !== {16'hC0DE, 16'(10 + i)})
        $display("FAIL resume_pop%0d: got %p want pc %h", i, pop_pc, 16'(10 + i));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_back_pressure();
    test_redirect_wait();
    test_redirect_ready_pop();
    test_wrap();
    test_stall();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
